// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: the controller
// state encoding and the width of its state vector.
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_r;

  // Count register: clear, then increment unless already at the ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates load-use, branch,
// multi-cycle multiply and data-memory wait hazards into stage enables/bubbles.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             br_taken,
  input  logic             mul_start,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [STATE_W-1:0] ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MCNT_W = 4;
  localparam bit MUL_MULTI = (MUL_LAT >= 2);
  localparam bit MUL_SHORT = (MUL_LAT == 2);
  localparam logic [MCNT_W-1:0] MUL_INIT = MCNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

  // Control word: {pc, if_id, id_ex, ex_mem, mem_wb enables, then the four flushes}
  localparam logic [8:0] CTL_OFF = 9'b00000_0000;
  localparam logic [8:0] CTL_RUN = 9'b11111_0000;
  localparam logic [8:0] CTL_MEM = 9'b00001_0001;
  localparam logic [8:0] CTL_BR  = 9'b11111_1100;
  localparam logic [8:0] CTL_MUL = 9'b00011_0010;
  localparam logic [8:0] CTL_FRZ = 9'b00111_0100;

  ctrl_state_e        state_r;
  ctrl_state_e        state_nxt_s;
  logic [MCNT_W-1:0]  mul_cnt_r;
  logic [MCNT_W-1:0]  mul_cnt_nxt_s;
  logic [8:0]         ctl_s;
  logic               stall_inc_s;

  // Hazard arbitration: pick the control word and next state for this cycle.
  always_comb begin
    ctl_s         = CTL_RUN;
    state_nxt_s   = ST_RUN;
    mul_cnt_nxt_s = mul_cnt_r;
    if (rst) begin
      ctl_s         = CTL_OFF;
      state_nxt_s   = ST_RUN;
      mul_cnt_nxt_s = {MCNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_busy) begin
            ctl_s       = CTL_MEM;
            state_nxt_s = ST_MEM_WAIT;
          end else if (br_taken) begin
            ctl_s = CTL_BR;
          end else if (mul_start && MUL_MULTI) begin
            ctl_s         = CTL_MUL;
            mul_cnt_nxt_s = MUL_INIT;
            state_nxt_s   = MUL_SHORT ? ST_RUN : ST_MUL_BUSY;
          end else if (freeze) begin
            ctl_s = CTL_FRZ;
          end else begin
            ctl_s = CTL_RUN;
          end
        end
        ST_MUL_BUSY: begin
          // A memory wait overrides the multiply stall and pauses its countdown.
          if (mem_busy) begin
            ctl_s       = CTL_MEM;
            state_nxt_s = ST_MUL_BUSY;
          end else begin
            ctl_s         = CTL_MUL;
            mul_cnt_nxt_s = mul_cnt_r - 4'd1;
            state_nxt_s   = (mul_cnt_r <= 4'd1) ? ST_RUN : ST_MUL_BUSY;
          end
        end
        default: begin
          ctl_s       = CTL_RUN;
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // State and multiply countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      mul_cnt_r <= {MCNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      mul_cnt_r <= mul_cnt_nxt_s;
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = ctl_s;

  assign ctrl_state  = state_r;
  assign stall_inc_s = ~pc_en & ~rst;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall_inc_s),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, random
// stimulus against a behavioural model, and a narrow-counter saturation run.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 3;

  localparam logic [8:0] O_OFF = 9'b00000_0000;
  localparam logic [8:0] O_RUN = 9'b11111_0000;
  localparam logic [8:0] O_MEM = 9'b00001_0001;
  localparam logic [8:0] O_BR  = 9'b11111_1100;
  localparam logic [8:0] O_MUL = 9'b00011_0010;
  localparam logic [8:0] O_FRZ = 9'b00111_0100;

  logic clk = 1'b0;
  logic rst, freeze, br_taken, mul_start, mem_busy, perf_clr;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;

  logic s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
  logic [1:0] s_ctrl_state;
  logic [3:0] s_stall_cnt;

  logic [8:0] outs;
  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .mul_start(mul_start), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .mul_start(mul_start), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
    .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
    .ctrl_state(s_ctrl_state), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic [5:0] in;   // {rst, freeze, br_taken, mul_start, mem_busy, perf_clr}
    logic [8:0] out;
    logic [1:0] st;
    int         cnt;
  } vec_t;

  vec_t tbl[30];
  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: remaining multiply stall cycles, wait flag, stall count.
  int m_mul_left = 0;
  bit m_mem_wait = 1'b0;
  int m_cnt = 0;

  function automatic vec_t mk(logic [5:0] in, logic [8:0] o, logic [1:0] st, int cnt);
    vec_t v;
    v.in = in; v.out = o; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [5:0] in);
    {rst, freeze, br_taken, mul_start, mem_busy, perf_clr} = in;
  endtask

  // One model-checked cycle: called at a falling edge, returns at the next one.
  task automatic model_cycle(input logic [5:0] in);
    logic [8:0] exp_o;
    logic [1:0] exp_st;
    bit r, fz, br, ml, mb, cl;
    {r, fz, br, ml, mb, cl} = in;
    drive(in);
    #1;
    if (r) begin
      m_mul_left = 0; m_mem_wait = 1'b0; m_cnt = 0;
      exp_o = O_OFF; exp_st = 2'd0;
    end else if (m_mul_left > 0) begin
      exp_st = 2'd1;
      if (mb) exp_o = O_MEM;
      else begin exp_o = O_MUL; m_mul_left--; end
    end else begin
      exp_st = m_mem_wait ? 2'd2 : 2'd0;
      m_mem_wait = 1'b0;
      if (mb) begin exp_o = O_MEM; m_mem_wait = 1'b1; end
      else if (br) exp_o = O_BR;
      else if (ml && MUL_LAT >= 2) begin exp_o = O_MUL; m_mul_left = MUL_LAT - 2; end
      else if (fz) exp_o = O_FRZ;
      else exp_o = O_RUN;
    end
    check("rand_outs", 32'(outs), 32'(exp_o));
    check("rand_state", 32'(ctrl_state), 32'(exp_st));
    check("rand_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (!r) begin
      if (cl) m_cnt = 0;
      else if (exp_o[8] == 1'b0 && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = mk(6'b100000, O_OFF, 2'd0, 0);
    tbl[1]  = mk(6'b000000, O_RUN, 2'd0, 0);
    tbl[2]  = mk(6'b010000, O_FRZ, 2'd0, 0);
    tbl[3]  = mk(6'b000000, O_RUN, 2'd0, 1);
    tbl[4]  = mk(6'b011000, O_BR,  2'd0, 1);
    tbl[5]  = mk(6'b000000, O_RUN, 2'd0, 1);
    tbl[6]  = mk(6'b000100, O_MUL, 2'd0, 1);
    tbl[7]  = mk(6'b000000, O_MUL, 2'd1, 2);
    tbl[8]  = mk(6'b000000, O_RUN, 2'd0, 3);
    tbl[9]  = mk(6'b000001, O_RUN, 2'd0, 3);
    tbl[10] = mk(6'b000100, O_MUL, 2'd0, 0);
    tbl[11] = mk(6'b000010, O_MEM, 2'd1, 1);
    tbl[12] = mk(6'b000010, O_MEM, 2'd1, 2);
    tbl[13] = mk(6'b000010, O_MEM, 2'd1, 3);
    tbl[14] = mk(6'b000000, O_MUL, 2'd1, 4);
    tbl[15] = mk(6'b000000, O_RUN, 2'd0, 5);
    tbl[16] = mk(6'b000010, O_MEM, 2'd0, 5);
    tbl[17] = mk(6'b010000, O_FRZ, 2'd2, 6);
    tbl[18] = mk(6'b000000, O_RUN, 2'd0, 7);
    tbl[19] = mk(6'b000100, O_MUL, 2'd0, 7);
    tbl[20] = mk(6'b100000, O_OFF, 2'd0, 0);
    tbl[21] = mk(6'b000000, O_RUN, 2'd0, 0);
    tbl[22] = mk(6'b001010, O_MEM, 2'd0, 0);
    tbl[23] = mk(6'b001000, O_BR,  2'd2, 1);
    tbl[24] = mk(6'b000000, O_RUN, 2'd0, 1);
    tbl[25] = mk(6'b010100, O_MUL, 2'd0, 1);
    tbl[26] = mk(6'b011100, O_MUL, 2'd1, 2);
    tbl[27] = mk(6'b000000, O_RUN, 2'd0, 3);
    tbl[28] = mk(6'b010001, O_FRZ, 2'd0, 3);
    tbl[29] = mk(6'b000000, O_RUN, 2'd0, 0);

    drive(6'b100000);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].in);
      #1;
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].out));
      check($sformatf("vec%0d_state", i), 32'(ctrl_state), 32'(tbl[i].st));
      check($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
      @(posedge clk);
      @(negedge clk);
    end

    // Randomised run against the model, starting from a reset cycle.
    model_cycle(6'b100000);
    for (int i = 0; i < 400; i++) begin
      logic [5:0] in;
      in[5] = ($urandom_range(0, 99) < 1);
      in[4] = ($urandom_range(0, 99) < 25);
      in[3] = ($urandom_range(0, 99) < 10);
      in[2] = ($urandom_range(0, 99) < 12);
      in[1] = ($urandom_range(0, 99) < 15);
      in[0] = ($urandom_range(0, 99) < 3);
      model_cycle(in);
    end

    // Narrow counter saturation: freeze held for 20 cycles, then a clear.
    drive(6'b100000);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive(6'b010000);
      @(negedge clk);
    end
    drive(6'b000000);
    #1;
    check("sat_cnt4", 32'(s_stall_cnt), 32'd15);
    check("sat_cnt16", 32'(stall_cnt), 32'd20);
    check("sat_outs", 32'(outs), 32'(O_RUN));
    @(negedge clk);
    drive(6'b000001);
    @(negedge clk);
    drive(6'b000000);
    #1;
    check("clr_cnt4", 32'(s_stall_cnt), 32'd0);
    check("clr_cnt16", 32'(stall_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
